// File: rtl/psum_out_serializer.sv
// psum_out_serializer
// Captures whole dual-core partial-sum vectors into a small circular buffer and
// streams them out one bw_psum-bit word per beat over a valid/ready handshake.
// Word order is 0..2*col-1; words col..2*col-1 belong to core 1.
// Optional build macro: PSUM_RELU_EN clamps negative words to zero on output.

module psum_out_serializer #(
    parameter int col     = 8,
    parameter int bw_psum = 20,
    parameter int depth   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_wr,
    input  logic [2*col*bw_psum-1:0]   in_data,
    output logic                       full,
    output logic [bw_psum-1:0]         out_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic                       out_last,
    output logic                       out_core,
    output logic                       ovf_err
);

    localparam int NWORDS = 2 * col;
    localparam int VEC_W  = NWORDS * bw_psum;
    localparam int PTR_W  = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W  = $clog2(depth + 1);
    localparam int WIDX_W = $clog2(NWORDS);

    localparam logic [PTR_W-1:0]  PTR_MAX    = PTR_W'(depth - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(depth);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [WIDX_W-1:0] WIDX_LAST  = WIDX_W'(NWORDS - 1);
    localparam logic [WIDX_W-1:0] WIDX_CORE1 = WIDX_W'(col);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Optional clamp of negative two's-complement words, applied on load into out_data.
    function automatic logic [bw_psum-1:0] relu(input logic [bw_psum-1:0] w);
`ifdef PSUM_RELU_EN
        return w[bw_psum-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    logic [VEC_W-1:0]   buf_mem [depth];

    state_t             state_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [WIDX_W-1:0]  widx_reg;
    logic [bw_psum-1:0] out_data_reg;
    logic               out_vld_reg;
    logic               out_last_reg;
    logic               out_core_reg;
    logic               ovf_err_reg;

    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [PTR_W-1:0]   load_ptr;
    logic [WIDX_W-1:0]  widx_next;
    logic [WIDX_W-1:0]  load_idx;
    logic [VEC_W-1:0]   load_vec;
    logic [bw_psum-1:0] load_words [NWORDS];
    logic [bw_psum-1:0] load_word;

    // Capture is gated on the occupancy held before the edge, so a pop in the
    // same cycle does not make room for a write that arrives while full.
    assign full        = (count_reg == CNT_FULL);
    assign push        = in_wr && !full;
    assign pop         = (state_reg == SEND) && out_vld_reg && out_rdy && (widx_reg == WIDX_LAST);
    assign wr_ptr_next = (wr_ptr_reg == PTR_MAX) ? '0 : wr_ptr_reg + 1'b1;
    assign rd_ptr_next = (rd_ptr_reg == PTR_MAX) ? '0 : rd_ptr_reg + 1'b1;
    assign widx_next   = widx_reg + 1'b1;

    // Word to load next: the following word of the head entry, or word 0 of the
    // head (after a pop, the new head) when starting a vector.
    assign load_ptr = pop ? rd_ptr_next : rd_ptr_reg;
    assign load_idx = ((state_reg == SEND) && !pop) ? widx_next : '0;
    assign load_vec = buf_mem[load_ptr];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_split
            assign load_words[gi] = load_vec[gi*bw_psum +: bw_psum];
        end
    endgenerate

    assign load_word = relu(load_words[load_idx]);

    // Vector storage; read through the registered out_data path.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_reg] <= in_data;
        end
    end

    // Buffer bookkeeping: pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ovf_err_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            if (in_wr && full) begin
                ovf_err_reg <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Serializer FSM with registered word, valid, last and core outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            widx_reg     <= '0;
            out_data_reg <= '0;
            out_vld_reg  <= 1'b0;
            out_last_reg <= 1'b0;
            out_core_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        out_data_reg <= load_word;
                        out_vld_reg  <= 1'b1;
                        out_last_reg <= 1'b0;
                        out_core_reg <= 1'b0;
                        widx_reg     <= '0;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (out_vld_reg && out_rdy) begin
                        if (widx_reg != WIDX_LAST) begin
                            widx_reg     <= widx_next;
                            out_data_reg <= load_word;
                            out_last_reg <= (widx_next == WIDX_LAST);
                            out_core_reg <= (widx_next >= WIDX_CORE1);
                        end else if (count_reg > CNT_ONE) begin
                            // Another vector was already buffered: no bubble.
                            widx_reg     <= '0;
                            out_data_reg <= load_word;
                            out_last_reg <= 1'b0;
                            out_core_reg <= 1'b0;
                        end else begin
                            widx_reg     <= '0;
                            out_data_reg <= '0;
                            out_vld_reg  <= 1'b0;
                            out_last_reg <= 1'b0;
                            out_core_reg <= 1'b0;
                            state_reg    <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_data = out_data_reg;
    assign out_vld  = out_vld_reg;
    assign out_last = out_last_reg;
    assign out_core = out_core_reg;
    assign ovf_err  = ovf_err_reg;

endmodule
